// File: rtl/risc_run_checker.sv
// risc_run_checker
// Run-and-check sequencer for the VeriRISC CPU. For each selected test it
// asks the loader for the program, drives the CPU reset sequence, counts RUN
// clocks and checks that halt rises on exactly the expected clock. It can run
// a single table entry, or every enabled entry in ascending index order.
//
// Ports
//   clk        single clock, shared with the CPU
//   rst        synchronous active-low reset
//   cfg_we     table write strobe (ignored while busy)
//   cfg_addr   table entry index
//   cfg_data   expected clock count N (clamped to 2^CNT_W-3)
//   cfg_en     entry enable, written together with cfg_data
//   start      one-cycle run request, accepted only in IDLE
//   seq        with start: 0 = run test_id only, 1 = run all enabled entries
//   test_id    entry to run when seq=0
//   load_ack   loader has finished loading cur_test
//   halt       CPU halt output
//   cpu_rst    active-high CPU reset
//   load_req   program load request for cur_test
//   cur_test   test currently loading/running (failing index on a failure)
//   busy       high while a run is in progress
//   done       one-cycle completion pulse
//   pass       result, held until the next accepted start
//   fail_code  00 none, 01 early halt, 10 late/no halt; held like pass
//   cycles     RUN count at the terminating decision; held like pass
module risc_run_checker #(
  parameter int CNT_W   = 12,
  parameter int N_TESTS = 8,
  parameter int ID_W    = $clog2(N_TESTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [ID_W-1:0]  cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             cfg_en,
  input  logic             start,
  input  logic             seq,
  input  logic [ID_W-1:0]  test_id,
  input  logic             load_ack,
  input  logic             halt,
  output logic             cpu_rst,
  output logic             load_req,
  output logic [ID_W-1:0]  cur_test,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RST1, S_RST0, S_RUN, S_DONE
  } state_e;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_EARLY = 2'b01;
  localparam logic [1:0] FC_LATE  = 2'b10;

  // Largest storable N: keeps the decision count N+2 inside CNT_W bits.
  localparam logic [CNT_W-1:0] EXP_MAX = {{(CNT_W-2){1'b1}}, 2'b01};

  state_e                        state_q, state_d;
  logic [N_TESTS-1:0][CNT_W-1:0] exp_q;
  logic [N_TESTS-1:0]            en_q;
  logic [ID_W-1:0]               cur_q, cur_d;
  logic                          seq_q, seq_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          pass_q, pass_d;
  logic [1:0]                    fail_q, fail_d;
  logic [CNT_W-1:0]              cycles_q, cycles_d;

  // ---------------------------------------------------------------------------
  // Expected-cycle table
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] wr_val;
  assign wr_val = (cfg_data > EXP_MAX) ? EXP_MAX : cfg_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_q <= '0;
      en_q  <= '0;
    end else if (cfg_we && !busy) begin
      exp_q[cfg_addr] <= wr_val;
      en_q[cfg_addr]  <= cfg_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Enabled-entry search: lowest enabled overall (sequence start) and lowest
  // enabled strictly above cur_q (next test in a sequence). Descending scan so
  // the last hit is the lowest index.
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0] first_idx, next_idx;
  logic            first_vld, next_vld;

  always_comb begin
    first_idx = '0;
    first_vld = 1'b0;
    next_idx  = '0;
    next_vld  = 1'b0;
    for (int i = N_TESTS - 1; i >= 0; i--) begin
      if (en_q[i]) begin
        first_idx = ID_W'(i);
        first_vld = 1'b1;
        if (ID_W'(i) > cur_q) begin
          next_idx = ID_W'(i);
          next_vld = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RUN-edge arithmetic, one bit wider so N+1 / N+2 never wrap.
  // ---------------------------------------------------------------------------
  logic [CNT_W:0] c_ext, n_ext;
  logic           halt_early, at_deadline;

  assign c_ext       = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign n_ext       = {1'b0, exp_q[cur_q]};
  assign halt_early  = halt && (c_ext <= n_ext + (CNT_W+1)'(1));
  assign at_deadline = (c_ext == n_ext + (CNT_W+1)'(2));

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      seq_q    <= 1'b0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      fail_q   <= FC_NONE;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      seq_q    <= seq_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    cycles_d = cycles_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Results of the previous run are cleared by the new request.
          pass_d   = 1'b0;
          fail_d   = FC_NONE;
          cycles_d = '0;
          seq_d    = seq;
          if (!seq) begin
            cur_d   = test_id;
            state_d = S_LOAD;
          end else if (first_vld) begin
            cur_d   = first_idx;
            state_d = S_LOAD;
          end else begin
            // Empty sequence passes trivially.
            cur_d   = '0;
            pass_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (load_ack) state_d = S_RST1;
      end
      S_RST1: state_d = S_RST0;
      S_RST0: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = c_ext[CNT_W-1:0];
        if (halt_early) begin
          fail_d   = FC_EARLY;
          cycles_d = c_ext[CNT_W-1:0];
          state_d  = S_DONE;
        end else if (at_deadline) begin
          cycles_d = c_ext[CNT_W-1:0];
          if (!halt) begin
            fail_d  = FC_LATE;
            state_d = S_DONE;
          end else if (seq_q && next_vld) begin
            // Straight into the next load, no idle gap.
            cur_d   = next_idx;
            state_d = S_LOAD;
          end else begin
            pass_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state
  // ---------------------------------------------------------------------------
  assign cpu_rst   = !((state_q == S_RST0) || (state_q == S_RUN));
  assign load_req  = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_RST1) ||
                     (state_q == S_RST0) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign cur_test  = cur_q;
  assign pass      = pass_q;
  assign fail_code = fail_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_risc_run_checker.sv
// Bench for risc_run_checker: behavioural loader and halt stubs plus a
// result/latency model computed from the halt-timing rules.
module tb_risc_run_checker;
  localparam int CNT_W   = 12;
  localparam int N_TESTS = 8;
  localparam int ID_W    = 3;
  localparam int EXP_MAX = (1 << CNT_W) - 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_we = 1'b0;
  logic [ID_W-1:0]  cfg_addr = '0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic             cfg_en = 1'b0;
  logic             start = 1'b0;
  logic             seq = 1'b0;
  logic [ID_W-1:0]  test_id = '0;
  logic             load_ack;
  logic             halt;
  logic             cpu_rst, load_req, busy, done, pass;
  logic [ID_W-1:0]  cur_test;
  logic [1:0]       fail_code;
  logic [CNT_W-1:0] cycles;

  risc_run_checker #(.CNT_W(CNT_W), .N_TESTS(N_TESTS)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_en(cfg_en), .start(start), .seq(seq),
    .test_id(test_id), .load_ack(load_ack), .halt(halt),
    .cpu_rst(cpu_rst), .load_req(load_req), .cur_test(cur_test),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference table mirror and per-entry program behaviour (halt after k RUN
  // edges, -1 = never halts).
  int exp_m [N_TESTS];
  bit en_m  [N_TESTS];
  int k_tab [N_TESTS];
  int ld_delay = 0;

  // Loader stub: acks after ld_delay cycles of load_req, logs each load.
  int ld_cnt = 0;
  int loads_q[$];
  always @(posedge clk) begin
    if (!load_req) ld_cnt <= 0;
    else           ld_cnt <= ld_cnt + 1;
    if (load_req && load_ack) loads_q.push_back(int'(cur_test));
  end
  assign load_ack = load_req && (ld_cnt >= ld_delay);

  // CPU halt stub: counts clocks with reset released.
  int stub_cnt = 0;
  always @(posedge clk) begin
    if (cpu_rst) stub_cnt <= 0;
    else         stub_cnt <= stub_cnt + 1;
  end
  assign halt = (k_tab[cur_test] >= 0) && (stub_cnt > k_tab[cur_test]);

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One test: halt first seen high at RUN count k+1.
  function automatic void model_one(int n, int k, output bit p,
                                    output int fc, output int cyc);
    if (k >= 0 && k <= n)  begin p = 1'b0; fc = 1; cyc = k + 1; end
    else if (k == n + 1)   begin p = 1'b1; fc = 0; cyc = n + 2; end
    else                   begin p = 1'b0; fc = 2; cyc = n + 2; end
  endfunction

  task automatic cfg_write(int addr, int data, bit en);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = ID_W'(addr); cfg_data = CNT_W'(data); cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
    exp_m[addr] = (data > EXP_MAX) ? EXP_MAX : data;
    en_m[addr]  = en;
  endtask

  // inj: 0 none, 1 table write while busy, 2 start pulse during RUN.
  task automatic do_run(string nm, bit s, int id, int inj);
    bit ep, p; int efc, ecyc, elat, f, c, wcnt;
    bit injected, low_seen;
    int eloads[$];
    ep = 1'b1; efc = 0; ecyc = 0; elat = 0;
    if (!s) begin
      model_one(exp_m[id], k_tab[id], ep, efc, ecyc);
      eloads.push_back(id);
      elat = ld_delay + 3 + ecyc;
    end else begin
      for (int i = 0; i < N_TESTS; i++) begin
        if (en_m[i]) begin
          model_one(exp_m[i], k_tab[i], p, f, c);
          eloads.push_back(i);
          elat += ld_delay + 3 + c;
          ep = p; efc = f; ecyc = c;
          if (!p) break;
        end
      end
    end
    loads_q.delete();
    @(negedge clk);
    start = 1'b1; seq = s; test_id = ID_W'(id);
    @(negedge clk);
    start = 1'b0; seq = 1'b0;
    check({nm, ".busy_start"}, busy, eloads.size() != 0);
    wcnt = 0; injected = 1'b0; low_seen = 1'b0;
    while (!done && wcnt < 20000) begin
      if (inj == 1 && !injected) begin
        cfg_we = 1'b1; cfg_addr = ID_W'(id); cfg_data = 12'd50; cfg_en = ~en_m[id];
        injected = 1'b1;
      end else if (inj == 2 && !injected && !cpu_rst) begin
        if (low_seen) begin
          start = 1'b1; seq = 1'b1; test_id = ID_W'(id + 1); injected = 1'b1;
        end
        low_seen = 1'b1;
      end
      @(negedge clk);
      cfg_we = 1'b0; start = 1'b0; seq = 1'b0;
      wcnt++;
    end
    check({nm, ".done"}, done, 1);
    check({nm, ".latency"}, wcnt, elat);
    check({nm, ".pass"}, pass, ep);
    check({nm, ".fail_code"}, fail_code, efc);
    check({nm, ".cycles"}, cycles, ecyc);
    if (eloads.size() != 0) check({nm, ".cur_test"}, cur_test, eloads[$]);
    check({nm, ".n_loads"}, loads_q.size(), eloads.size());
    for (int i = 0; i < eloads.size(); i++)
      if (i < loads_q.size()) check($sformatf("%s.load%0d", nm, i), loads_q[i], eloads[i]);
    @(negedge clk);
    check({nm, ".done_pulse"}, done, 0);
    check({nm, ".busy_after"}, busy, 0);
    check({nm, ".pass_held"}, pass, ep);
    check({nm, ".cycles_held"}, cycles, ecyc);
  endtask

  initial begin
    int n, r, k, dcount;
    for (int i = 0; i < N_TESTS; i++) begin exp_m[i] = 0; en_m[i] = 0; k_tab[i] = -1; end

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.cpu_rst", cpu_rst, 1);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.load_req", load_req, 0);
    check("rst.pass", pass, 0);
    check("rst.fail_code", fail_code, 0);
    check("rst.cycles", cycles, 0);
    check("rst.cur_test", cur_test, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed single runs on entry 0 with N=2
    cfg_write(0, 2, 1'b1);
    k_tab[0] = 3;  do_run("single_pass", 1'b0, 0, 0);
    check("single_pass.cycles_const", cycles, 4);
    k_tab[0] = 2;  do_run("single_early", 1'b0, 0, 0);
    check("single_early.code_const", fail_code, 1);
    k_tab[0] = -1; do_run("single_never", 1'b0, 0, 0);
    check("single_never.code_const", fail_code, 2);

    // Sequence over entries 1/3/5
    cfg_write(0, 2, 1'b0);
    cfg_write(1, 10, 1'b1); k_tab[1] = 11;
    cfg_write(3, 18, 1'b1); k_tab[3] = 19;
    cfg_write(5, 34, 1'b1); k_tab[5] = 35;
    ld_delay = 2;
    do_run("seq_pass", 1'b1, 0, 0);
    k_tab[3] = 20;
    do_run("seq_late3", 1'b1, 0, 0);
    k_tab[3] = 19;

    // Clamp on write, write-while-busy ignored, start during RUN ignored
    ld_delay = 0;
    cfg_write(2, 4095, 1'b1); k_tab[2] = EXP_MAX + 1;
    do_run("clamp", 1'b0, 2, 0);
    k_tab[0] = 3;
    ld_delay = 3;
    do_run("cfg_busy", 1'b0, 0, 1);
    do_run("start_run", 1'b0, 0, 2);

    // Randomized single runs
    for (int t = 0; t < 12; t++) begin
      int id;
      id = $urandom_range(0, N_TESTS - 1);
      n  = $urandom_range(0, 15);
      r  = $urandom_range(0, 5);
      case (r)
        0: k = -1;
        1: k = n + 1;
        2: k = n + 2;
        3: k = $urandom_range(0, n);
        4: k = n;
        default: k = n + 1 + $urandom_range(1, 4);
      endcase
      cfg_write(id, n, 1'($urandom_range(0, 1)));
      k_tab[id] = k;
      ld_delay = $urandom_range(0, 3);
      do_run($sformatf("rnd_single%0d", t), 1'b0, id, 0);
    end

    // Randomized sequences
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N_TESTS; i++) begin
        n = $urandom_range(0, 12);
        if ($urandom_range(0, 9) < 8) k = n + 1;
        else k = ($urandom_range(0, 1) == 1) ? n + 2 : $urandom_range(0, n);
        cfg_write(i, n, 1'($urandom_range(0, 1)));
        k_tab[i] = k;
      end
      ld_delay = $urandom_range(0, 3);
      do_run($sformatf("rnd_seq%0d", t), 1'b1, 0, 0);
    end

    // Reset during RUN
    ld_delay = 1;
    cfg_write(0, 5, 1'b1); k_tab[0] = 6;
    @(negedge clk); start = 1'b1; seq = 1'b0; test_id = '0;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (cpu_rst && n < 50) begin @(negedge clk); n++; end
    check("midrst.reached_run", cpu_rst, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst.cpu_rst", cpu_rst, 1);
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.load_req", load_req, 0);
    check("midrst.cycles", cycles, 0);
    check("midrst.cur_test", cur_test, 0);
    rst = 1'b1;
    for (int i = 0; i < N_TESTS; i++) begin exp_m[i] = 0; en_m[i] = 0; end
    dcount = 0;
    repeat (20) begin @(negedge clk); if (done) dcount++; end
    check("midrst.no_done", dcount, 0);

    // Cleared table: empty sequence, then entry 0 runs with N=0
    do_run("empty_seq", 1'b1, 0, 0);
    k_tab[0] = 1;
    do_run("cleared_exp", 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
